bus8_master: RTL and testbench
==============================

# bus8_master

Bus initiator for the 8-bit FPGA register bus: accepts single read/write commands on a valid/ready command port and drives one bus transaction per command toward register-bank responders (chip select, write/read-not, address, write data). It collects read data from the responder's data-valid strobe and returns a one-cycle response for every command, with a read timeout. It sits between a command source (UART/SPI command decoder, test sequencer) and the shared bus responders.

## Interface
- ADDR_WIDTH, 8, bus address width in bits (≥1)
- TIMEOUT_CYCLES, 16, read wait-window length in clock cycles (≥1)

- i_Bus_Clk  in  1  bus clock; all logic on rising edge
- i_Bus_Rst  in  1  reset, asynchronous, active-high
- i_Cmd_Valid  in  1  command present
- o_Cmd_Ready  out  1  block can accept a command this cycle
- i_Cmd_Wr_Rd_n  in  1  1 = write, 0 = read
- i_Cmd_Addr  in  ADDR_WIDTH  target register address
- i_Cmd_Wr_Data  in  8  write data (ignored for reads)
- o_Rsp_Valid  out  1  one-cycle response pulse, one per accepted command
- o_Rsp_Rd_Data  out  8  read data (0x00 for writes and timeouts)
- o_Rsp_Timeout  out  1  1 = read got no data-valid within window
- o_Bus_CS  out  1  bus chip select, one-cycle strobe per transaction
- o_Bus_Wr_Rd_n  out  1  bus direction, qualified by o_Bus_CS
- o_Bus_Addr  out  ADDR_WIDTH  bus address, qualified by o_Bus_CS
- o_Bus_Wr_Data  out  8  bus write data, qualified by o_Bus_CS
- i_Bus_Rd_Data  in  8  responder read data, qualified by i_Bus_Rd_DV
- i_Bus_Rd_DV  in  1  responder read data valid

## Operation
- All outputs registered. Reset values: o_Cmd_Ready=1, all other outputs 0, state IDLE, timeout counter 0.
- States: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE: o_Cmd_Ready=1. i_Cmd_Valid & o_Cmd_Ready → capture Wr_Rd_n/Addr/Wr_Data, o_Cmd_Ready→0, go ISSUE.
- ISSUE: o_Bus_CS=1 for exactly this cycle with captured direction/address/data. Write → RESP. Read → WAIT_RD, counter cleared.
- WAIT_RD: i_Bus_Rd_DV=1 → capture i_Bus_Rd_Data, Timeout=0, go RESP. Else counter+1; on the TIMEOUT_CYCLES-th cycle without DV → data 0x00, Timeout=1, go RESP. DV on that final cycle wins over timeout.
- RESP: o_Rsp_Valid=1 for exactly this cycle; next state IDLE, o_Cmd_Ready→1.
- No response backpressure; consumer must take the pulse.
- o_Rsp_Rd_Data / o_Rsp_Timeout hold until next response; meaningful only with o_Rsp_Valid. o_Bus_Addr/Wr_Data/Wr_Rd_n hold last values between strobes.
- Command inputs ignored while o_Cmd_Ready=0. i_Bus_Rd_DV ignored outside WAIT_RD (stray or late DV dropped, no effect).
- Counter width $clog2(TIMEOUT_CYCLES+1); no wrap possible.
- Reset mid-operation: immediate return to reset values; in-flight command dropped, no o_Rsp_Valid.

## Timing
- Handshake cycle N (IDLE). o_Bus_CS high cycle N+1.
- Write: o_Rsp_Valid cycle N+2; o_Cmd_Ready high N+3; next accept earliest N+3 (3-cycle throughput).
- Read, responder DV at N+2 (one-cycle responder latency): o_Rsp_Valid N+3; o_Cmd_Ready high N+4.
- Read, DV at N+1+k (1≤k≤TIMEOUT_CYCLES): o_Rsp_Valid N+2+k.
- Read timeout: o_Rsp_Valid with Timeout=1 at N+2+TIMEOUT_CYCLES.

## Test plan
- Write addr 0x03 data 0xA5 at N → CS=1, Wr_Rd_n=1, Addr=0x03, Wr_Data=0xA5 at N+1 only; Rsp_Valid at N+2, Timeout=0, Rd_Data=0x00; register-bank model reg 3 = 0xA5.
- Read addr 0x03 against bank model (one-cycle latency) after above → CS at N+1 with Wr_Rd_n=0; Rsp_Valid at N+3, Rd_Data=0xA5, Timeout=0.
- Read with DV never asserted, TIMEOUT_CYCLES=16 → Rsp_Valid at N+18, Timeout=1, Rd_Data=0x00; DV at N+18 afterwards ignored, state IDLE.
- DV with data 0x3C exactly on cycle N+17 (last window cycle) → Rsp_Valid N+18, Rd_Data=0x3C, Timeout=0.
- i_Cmd_Valid held high, four writes with changing inputs → accepts every 3rd cycle only, one CS and one Rsp per accept, inputs during busy ignored; stray DV in IDLE produces no response.
- Assert i_Bus_Rst asynchronously in WAIT_RD → outputs reset values within same cycle, no Rsp_Valid; release, then write 0x07/0xFF completes normally at N+2.

Source files
------------

// File: rtl/bus8_master.sv
// bus8_master: single-command initiator for the 8-bit register bus.
// Takes one read/write command per valid/ready handshake, strobes the bus
// for one cycle, collects read data (with a bounded wait window) and returns
// a one-cycle response for every accepted command.
module bus8_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  i_Bus_Clk,
    input  logic                  i_Bus_Rst,
    input  logic                  i_Cmd_Valid,
    output logic                  o_Cmd_Ready,
    input  logic                  i_Cmd_Wr_Rd_n,
    input  logic [ADDR_WIDTH-1:0] i_Cmd_Addr,
    input  logic [7:0]            i_Cmd_Wr_Data,
    output logic                  o_Rsp_Valid,
    output logic [7:0]            o_Rsp_Rd_Data,
    output logic                  o_Rsp_Timeout,
    output logic                  o_Bus_CS,
    output logic                  o_Bus_Wr_Rd_n,
    output logic [ADDR_WIDTH-1:0] o_Bus_Addr,
    output logic [7:0]            o_Bus_Wr_Data,
    input  logic [7:0]            i_Bus_Rd_Data,
    input  logic                  i_Bus_Rd_DV
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Count value reached on the last cycle of the read wait window.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_RD = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  cmd_ready_reg, cmd_ready_next;
    logic                  rsp_valid_reg, rsp_valid_next;
    logic [7:0]            rsp_rd_data_reg, rsp_rd_data_next;
    logic                  rsp_timeout_reg, rsp_timeout_next;
    logic                  bus_cs_reg, bus_cs_next;
    logic                  bus_wr_rd_n_reg, bus_wr_rd_n_next;
    logic [ADDR_WIDTH-1:0] bus_addr_reg, bus_addr_next;
    logic [7:0]            bus_wr_data_reg, bus_wr_data_next;

    // State, counter and every output register; all outputs come straight from flops.
    always_ff @(posedge i_Bus_Clk or posedge i_Bus_Rst) begin
        if (i_Bus_Rst) begin
            state_reg       <= S_IDLE;
            cnt_reg         <= '0;
            cmd_ready_reg   <= 1'b1;
            rsp_valid_reg   <= 1'b0;
            rsp_rd_data_reg <= 8'h00;
            rsp_timeout_reg <= 1'b0;
            bus_cs_reg      <= 1'b0;
            bus_wr_rd_n_reg <= 1'b0;
            bus_addr_reg    <= '0;
            bus_wr_data_reg <= 8'h00;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            cmd_ready_reg   <= cmd_ready_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_rd_data_reg <= rsp_rd_data_next;
            rsp_timeout_reg <= rsp_timeout_next;
            bus_cs_reg      <= bus_cs_next;
            bus_wr_rd_n_reg <= bus_wr_rd_n_next;
            bus_addr_reg    <= bus_addr_next;
            bus_wr_data_reg <= bus_wr_data_next;
        end
    end

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // so that CS lands in ISSUE and the response pulse lands in RESP.
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        cmd_ready_next   = cmd_ready_reg;
        rsp_valid_next   = 1'b0;
        rsp_rd_data_next = rsp_rd_data_reg;
        rsp_timeout_next = rsp_timeout_reg;
        bus_cs_next      = 1'b0;
        bus_wr_rd_n_next = bus_wr_rd_n_reg;
        bus_addr_next    = bus_addr_reg;
        bus_wr_data_next = bus_wr_data_reg;

        case (state_reg)
            S_IDLE: begin
                // The bus registers double as the command capture registers.
                if (i_Cmd_Valid && cmd_ready_reg) begin
                    cmd_ready_next   = 1'b0;
                    bus_cs_next      = 1'b1;
                    bus_wr_rd_n_next = i_Cmd_Wr_Rd_n;
                    bus_addr_next    = i_Cmd_Addr;
                    bus_wr_data_next = i_Cmd_Wr_Data;
                    state_next       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus_wr_rd_n_reg) begin
                    rsp_valid_next   = 1'b1;
                    rsp_rd_data_next = 8'h00;
                    rsp_timeout_next = 1'b0;
                    state_next       = S_RESP;
                end else begin
                    cnt_next   = '0;
                    state_next = S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                // Data-valid is checked first so it wins on the final window cycle.
                if (i_Bus_Rd_DV) begin
                    rsp_valid_next   = 1'b1;
                    rsp_rd_data_next = i_Bus_Rd_Data;
                    rsp_timeout_next = 1'b0;
                    state_next       = S_RESP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_LAST) begin
                        rsp_valid_next   = 1'b1;
                        rsp_rd_data_next = 8'h00;
                        rsp_timeout_next = 1'b1;
                        state_next       = S_RESP;
                    end
                end
            end
            S_RESP: begin
                cmd_ready_next = 1'b1;
                state_next     = S_IDLE;
            end
            default: begin
                cmd_ready_next = 1'b1;
                state_next     = S_IDLE;
            end
        endcase
    end

    assign o_Cmd_Ready   = cmd_ready_reg;
    assign o_Rsp_Valid   = rsp_valid_reg;
    assign o_Rsp_Rd_Data = rsp_rd_data_reg;
    assign o_Rsp_Timeout = rsp_timeout_reg;
    assign o_Bus_CS      = bus_cs_reg;
    assign o_Bus_Wr_Rd_n = bus_wr_rd_n_reg;
    assign o_Bus_Addr    = bus_addr_reg;
    assign o_Bus_Wr_Data = bus_wr_data_reg;

endmodule

// File: tb/tb_bus8_master.sv
// Testbench for bus8_master: register-bank responder model plus scoreboards
// for bus strobes and command responses, each tagged with its expected cycle.
module tb_bus8_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_wr = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rd_data;
    logic       rsp_timeout;
    logic       bus_cs;
    logic       bus_wr;
    logic [7:0] bus_addr;
    logic [7:0] bus_wr_data;
    logic [7:0] bus_rd_data;
    logic       bus_rd_dv;

    // Responder model drive and manual (test-controlled) drive, merged.
    logic       model_dv = 1'b0;
    logic [7:0] model_data = 8'h00;
    logic       model_pend = 1'b0;
    logic [7:0] model_addr = 8'h00;
    logic       man_dv = 1'b0;
    logic [7:0] man_data = 8'h00;
    logic       bank_en = 1'b1;
    logic [7:0] bank [256];

    assign bus_rd_dv   = model_dv | man_dv;
    assign bus_rd_data = model_dv ? model_data : man_data;

    typedef struct {
        logic [7:0] data;
        logic       to;
        int         cyc;
    } rsp_t;
    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } bus_t;

    rsp_t rsp_q[$];
    bus_t bus_q[$];
    rsp_t re;
    bus_t be;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int rsp_count = 0;
    int cs_count = 0;

    bus8_master #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .i_Bus_Clk     (clk),
        .i_Bus_Rst     (rst),
        .i_Cmd_Valid   (cmd_valid),
        .o_Cmd_Ready   (cmd_ready),
        .i_Cmd_Wr_Rd_n (cmd_wr),
        .i_Cmd_Addr    (cmd_addr),
        .i_Cmd_Wr_Data (cmd_data),
        .o_Rsp_Valid   (rsp_valid),
        .o_Rsp_Rd_Data (rsp_rd_data),
        .o_Rsp_Timeout (rsp_timeout),
        .o_Bus_CS      (bus_cs),
        .o_Bus_Wr_Rd_n (bus_wr),
        .o_Bus_Addr    (bus_addr),
        .o_Bus_Wr_Data (bus_wr_data),
        .i_Bus_Rd_Data (bus_rd_data),
        .i_Bus_Rd_DV   (bus_rd_dv)
    );

    always #5 clk = ~clk;

    // One clock cycle: observe on the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        if (bus_cs) begin
            cs_count++;
            if (bus_wr) bank[bus_addr] = bus_wr_data;
            else if (bank_en) begin
                model_pend = 1'b1;
                model_addr = bus_addr;
            end
            checks++;
            if (bus_q.size() == 0) begin
                errors++;
                $display("FAIL bus_cs_unexpected cyc=%0d got wr=%0b addr=%02h data=%02h required no strobe",
                         cyc, bus_wr, bus_addr, bus_wr_data);
            end else begin
                be = bus_q.pop_front();
                if (bus_wr !== be.wr || bus_addr !== be.addr || (be.wr && bus_wr_data !== be.data) || cyc != be.cyc) begin
                    errors++;
                    $display("FAIL bus_cs got wr=%0b addr=%02h data=%02h cyc=%0d required wr=%0b addr=%02h data=%02h cyc=%0d",
                             bus_wr, bus_addr, bus_wr_data, cyc, be.wr, be.addr, be.data, be.cyc);
                end
            end
        end
        if (rsp_valid) begin
            rsp_count++;
            checks++;
            if (rsp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected cyc=%0d got data=%02h to=%0b required no response",
                         cyc, rsp_rd_data, rsp_timeout);
            end else begin
                re = rsp_q.pop_front();
                if (rsp_rd_data !== re.data || rsp_timeout !== re.to || cyc != re.cyc) begin
                    errors++;
                    $display("FAIL rsp got data=%02h to=%0b cyc=%0d required data=%02h to=%0b cyc=%0d",
                             rsp_rd_data, rsp_timeout, cyc, re.data, re.to, re.cyc);
                end else begin
                    $display("rsp   cyc=%0d data=%02h to=%0b", cyc, rsp_rd_data, rsp_timeout);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        model_dv   = model_pend;
        model_data = bank[model_addr];
        model_pend = 1'b0;
    endtask

    // Wait for ready, present one command for one cycle and queue its expectations.
    // Returns in cycle N+1, where N is the handshake cycle.
    task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                         input logic [7:0] exp_data, input logic exp_to, input int lat);
        int n;
        rsp_t r;
        bus_t b;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_wait got ready=0 after %0d cycles required ready=1", n);
        end
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_data  = data;
        b.wr = wr; b.addr = addr; b.data = data; b.cyc = cyc + 1;
        bus_q.push_back(b);
        r.data = exp_data; r.to = exp_to; r.cyc = cyc + lat;
        rsp_q.push_back(r);
        $display("cmd   cyc=%0d wr=%0b addr=%02h data=%02h", cyc, wr, addr, data);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < max_cycles) begin
            tick();
            n++;
        end
        if (rsp_q.size() != 0 || bus_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d rsp / %0d bus pending required 0", rsp_q.size(), bus_q.size());
            rsp_q.delete();
            bus_q.delete();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) bank[i] = 8'h00;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({rsp_valid, rsp_rd_data, rsp_timeout, bus_cs, bus_wr, bus_addr, bus_wr_data} !== 28'h0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold got ready=%0b rsp=%0b cs=%0b required ready=1 rest 0", cmd_ready, rsp_valid, bus_cs);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({rsp_valid, rsp_rd_data, rsp_timeout, bus_cs, bus_wr, bus_addr, bus_wr_data} !== 28'h0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got ready=%0b rsp=%0b cs=%0b required ready=1 rest 0", cmd_ready, rsp_valid, bus_cs);
        end
    endtask

    task automatic test_write();
        bank_en = 1'b1;
        issue(1'b1, 8'h03, 8'hA5, 8'h00, 1'b0, 2);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_ready_n1 got %0b required 0", cmd_ready);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_ready_n2 got %0b required 0", cmd_ready);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_ready_n3 got %0b required 1", cmd_ready);
        end
        wait_drain(10);
        checks++;
        if (bank[3] !== 8'hA5) begin
            errors++;
            $display("FAIL write_bank got %02h required a5", bank[3]);
        end
    endtask

    task automatic test_read();
        bank_en = 1'b1;
        issue(1'b0, 8'h03, 8'h00, 8'hA5, 1'b0, 3);
        wait_drain(10);
    endtask

    task automatic test_timeout();
        int c0;
        bank_en = 1'b0;
        issue(1'b0, 8'h05, 8'h00, 8'h00, 1'b1, 18);
        repeat (17) tick();
        man_dv   = 1'b1;
        man_data = 8'h5A;
        tick();
        man_dv = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ready got %0b required 1", cmd_ready);
        end
        c0 = rsp_count;
        repeat (4) tick();
        checks++;
        if (rsp_count != c0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL late_dv got rsp=%0d ready=%0b required rsp=%0d ready=1", rsp_count - c0, cmd_ready, 0);
        end
        wait_drain(5);
        bank_en = 1'b1;
    endtask

    task automatic test_dv_last();
        bank_en = 1'b0;
        issue(1'b0, 8'h06, 8'h00, 8'h3C, 1'b0, 18);
        repeat (16) tick();
        man_dv   = 1'b1;
        man_data = 8'h3C;
        tick();
        man_dv = 1'b0;
        wait_drain(5);
        bank_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        int n0;
        int c0;
        int cs0;
        rsp_t r;
        bus_t b;
        bank_en = 1'b1;
        n0  = cyc;
        c0  = rsp_count;
        cs0 = cs_count;
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        for (int j = 0; j < 10; j++) begin
            cmd_addr = 8'h20 + 8'(j);
            cmd_data = 8'h11 * 8'(j);
            if (j % 3 == 0) begin
                b.wr = 1'b1; b.addr = cmd_addr; b.data = cmd_data; b.cyc = n0 + j + 1;
                bus_q.push_back(b);
                r.data = 8'h00; r.to = 1'b0; r.cyc = n0 + j + 2;
                rsp_q.push_back(r);
            end
            tick();
        end
        cmd_valid = 1'b0;
        wait_drain(10);
        checks++;
        if (cs_count - cs0 != 4 || rsp_count - c0 != 4) begin
            errors++;
            $display("FAIL b2b_counts got cs=%0d rsp=%0d required cs=4 rsp=4", cs_count - cs0, rsp_count - c0);
        end
        checks++;
        if (bank[8'h29] !== 8'h99 || bank[8'h21] !== 8'h00) begin
            errors++;
            $display("FAIL b2b_bank got r29=%02h r21=%02h required r29=99 r21=00", bank[8'h29], bank[8'h21]);
        end
        c0 = rsp_count;
        man_dv   = 1'b1;
        man_data = 8'hEE;
        repeat (2) tick();
        man_dv = 1'b0;
        repeat (3) tick();
        checks++;
        if (rsp_count != c0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL stray_dv got rsp=%0d ready=%0b required rsp=0 ready=1", rsp_count - c0, cmd_ready);
        end
    endtask

    task automatic test_async_reset();
        int c0;
        bank_en = 1'b0;
        issue(1'b0, 8'h08, 8'h00, 8'h00, 1'b1, 18);
        tick();
        tick();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, rsp_rd_data, rsp_timeout, bus_cs, bus_wr, bus_addr, bus_wr_data} !== 28'h0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got ready=%0b rsp=%0b cs=%0b addr=%02h required ready=1 rest 0",
                     cmd_ready, rsp_valid, bus_cs, bus_addr);
        end
        @(posedge clk);
        #1;
        cyc++;
        rsp_q.delete();
        c0 = rsp_count;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (rsp_count != c0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_drop got rsp=%0d ready=%0b required rsp=0 ready=1", rsp_count - c0, cmd_ready);
        end
        bank_en = 1'b1;
        issue(1'b1, 8'h07, 8'hFF, 8'h00, 1'b0, 2);
        wait_drain(10);
        checks++;
        if (bank[7] !== 8'hFF) begin
            errors++;
            $display("FAIL post_reset_write got %02h required ff", bank[7]);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_dv_last();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
